mem_wait_responder: RTL and testbench

- Word-addressed memory responder: the slave end of the CPU memory bus (addr/wdata/rdata/re/we/mem_ready).
- Inserts a configurable number of wait states before asserting mem_ready, so the CPU's stall path is exercised.
- Backed by internal RAM with byte-enable writes.
- Includes one memory-mapped status register that captures test results for benches and the FPGA top level.

---
 rtl/mem_wait_responder.sv | 196 +++++++++++++++++++
 tb/tb_mem_wait_responder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wait_responder.sv
// Word-addressed memory responder with configurable wait states, byte-enable RAM and a status register.
// Optional build macro MEM_RAND_WAIT_EN: per-request wait count drawn from an 8-bit LFSR.
module mem_wait_responder #(
    parameter int          NUM_WORDS   = 2048,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [29:0] STATUS_ADDR = 30'h3FFF_FFFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        re,
    input  logic [3:0]  we,
    output logic        mem_ready,
    output logic [31:0] status,
    output logic        status_valid,
    output logic        addr_err
);

    localparam int          IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [29:0] DEPTH     = 30'(NUM_WORDS);
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_wait_range_check
            $error("mem_wait_responder: WAIT_CYCLES must be within 0..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    logic [31:0] ram [0:NUM_WORDS-1];

    state_t      state_r, state_next_s;
    logic [3:0]  cnt_r, cnt_next_s;
    logic [29:0] addr_r;
    logic [31:0] wdata_r;
    logic [3:0]  we_r;
    logic        is_wr_r;
    logic        mem_ready_r;
    logic [31:0] rdata_r;
    logic [31:0] status_r;
    logic        status_valid_r;
    logic        addr_err_r;

    logic        req_s;
    logic        accept_s;
    logic [3:0]  wait_sel_s;
    logic [29:0] cur_addr_s;
    logic        cur_is_wr_s;
    logic [31:0] read_val_s;
    logic        lat_in_range_s;
    logic        lat_is_status_s;

    assign req_s           = re | (we != 4'b0000);
    assign lat_in_range_s  = (addr_r < DEPTH);
    assign lat_is_status_s = (addr_r == STATUS_ADDR);

`ifdef MEM_RAND_WAIT_EN
    localparam logic [4:0] WAIT_MOD = 5'(WAIT_CYCLES + 1);
    logic [7:0] lfsr_r;

    // Galois LFSR (x^8+x^6+x^5+x^4+1), stepped once per accepted request
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr_r <= 8'hA5;
        end else if (accept_s) begin
            lfsr_r <= lfsr_r[0] ? ((lfsr_r >> 1) ^ 8'hB8) : (lfsr_r >> 1);
        end
    end

    assign wait_sel_s = 4'({1'b0, lfsr_r[3:0]} % WAIT_MOD);
`else
    assign wait_sel_s = WAIT_LOAD;
`endif

    // Next-state and wait counter logic
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        accept_s     = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (req_s) begin
                    accept_s   = 1'b1;
                    cnt_next_s = wait_sel_s;
                    if (wait_sel_s != 4'd0) begin
                        state_next_s = S_WAIT;
                    end else begin
                        state_next_s = S_RESP;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_r <= 4'd1) begin
                    state_next_s = S_RESP;
                    cnt_next_s   = 4'd0;
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            S_RESP: begin
                state_next_s = S_IDLE;
                cnt_next_s   = 4'd0;
            end
            default: begin
                state_next_s = S_IDLE;
                cnt_next_s   = 4'd0;
            end
        endcase
    end

    // rdata is loaded on the edge entering RESP; with zero wait that is the accepting edge
    always_comb begin
        cur_addr_s  = accept_s ? addr : addr_r;
        cur_is_wr_s = accept_s ? (we != 4'b0000) : is_wr_r;
        if (cur_addr_s == STATUS_ADDR) begin
            read_val_s = status_r;
        end else if (cur_addr_s < DEPTH) begin
            read_val_s = ram[cur_addr_s[IDX_W-1:0]];
        end else begin
            read_val_s = 32'h0000_0000;
        end
    end

    // Control state, request latches and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= S_IDLE;
            cnt_r          <= 4'd0;
            addr_r         <= 30'd0;
            wdata_r        <= 32'd0;
            we_r           <= 4'd0;
            is_wr_r        <= 1'b0;
            mem_ready_r    <= 1'b0;
            rdata_r        <= 32'd0;
            status_r       <= 32'd0;
            status_valid_r <= 1'b0;
            addr_err_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            mem_ready_r <= (state_next_s == S_RESP);
            if (accept_s) begin
                addr_r  <= addr;
                wdata_r <= wdata;
                we_r    <= we;
                is_wr_r <= (we != 4'b0000);
            end
            if (state_next_s == S_RESP && !cur_is_wr_s) begin
                rdata_r <= read_val_s;
            end
            if (state_r == S_RESP) begin
                if (lat_is_status_s) begin
                    if (is_wr_r) begin
                        status_r       <= merge_bytes(status_r, wdata_r, we_r);
                        status_valid_r <= 1'b1;
                    end
                end else if (!lat_in_range_s) begin
                    addr_err_r <= 1'b1;
                end
            end
        end
    end

    // RAM byte-enable write, committed on the edge that ends RESP
    always_ff @(posedge clk) begin
        if (state_r == S_RESP && is_wr_r && lat_in_range_s && !lat_is_status_s) begin
            ram[addr_r[IDX_W-1:0]] <= merge_bytes(ram[addr_r[IDX_W-1:0]], wdata_r, we_r);
        end
    end

    assign mem_ready    = mem_ready_r;
    assign rdata        = rdata_r;
    assign status       = status_r;
    assign status_valid = status_valid_r;
    assign addr_err     = addr_err_r;

endmodule

// File: tb/tb_mem_wait_responder.sv
// Self-checking bench for mem_wait_responder: four instances with different wait settings,
// a scoreboard queue of expected responses, a vector table and hand-written corner sequences.
module tb_mem_wait_responder;

    localparam int          NI = 4;
    localparam int          NW = 2048;
    localparam logic [29:0] SA = 30'h3FFF_FFFF;
    localparam int          WC [NI] = '{2, 0, 3, 7};

    logic        clk = 1'b0;
    logic        reset_n_v      [NI];
    logic [29:0] addr_v         [NI];
    logic [31:0] wdata_v        [NI];
    logic [31:0] rdata_v        [NI];
    logic        re_v           [NI];
    logic [3:0]  we_v           [NI];
    logic        mem_ready_v    [NI];
    logic [31:0] status_v       [NI];
    logic        status_valid_v [NI];
    logic        addr_err_v     [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        mem_wait_responder #(
            .NUM_WORDS   (NW),
            .WAIT_CYCLES (WC[g]),
            .STATUS_ADDR (SA)
        ) u_dut (
            .clk          (clk),
            .reset_n      (reset_n_v[g]),
            .addr         (addr_v[g]),
            .wdata        (wdata_v[g]),
            .rdata        (rdata_v[g]),
            .re           (re_v[g]),
            .we           (we_v[g]),
            .mem_ready    (mem_ready_v[g]),
            .status       (status_v[g]),
            .status_valid (status_valid_v[g]),
            .addr_err     (addr_err_v[g])
        );
    end

    typedef struct {
        bit          chk;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    typedef struct {
        logic [29:0] addr;
        logic [31:0] wdata;
        logic        re;
        logic [3:0]  we;
        logic [31:0] exp_rdata;
        logic [31:0] exp_status;
        logic        exp_sv;
        logic        exp_ae;
    } vec_t;

    exp_t sb [$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_resp_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic do_txn(input int k, input string tag, input logic [29:0] a, input logic [31:0] d,
                          input logic r, input logic [3:0] w, input bit chk, input logic [31:0] exp_d,
                          input int exp_lat, output int got_lat);
        exp_t e;
        int   lat;
        bit   seen;
        @(negedge clk);
        check({tag, "_idle_low"}, 32'(mem_ready_v[k]), 32'd0);
        addr_v[k]  = a;
        wdata_v[k] = d;
        re_v[k]    = r;
        we_v[k]    = w;
        e.chk = chk;
        e.rdata = exp_d;
        e.lat = exp_lat;
        sb.push_back(e);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (mem_ready_v[k] === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        if (seen) begin
            check({tag, "_latency"}, 32'(lat), 32'(e.lat));
            if (e.chk) check({tag, "_rdata"}, rdata_v[k], e.rdata);
            last_resp_cyc = cyc;
            got_lat = lat;
        end else begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: no mem_ready after %0d cycles, expected latency %0d", tag, lat, e.lat);
            got_lat = -1;
        end
        addr_v[k]  = 30'd0;
        wdata_v[k] = 32'd0;
        re_v[k]    = 1'b0;
        we_v[k]    = 4'd0;
    endtask

    task automatic check_reset_vals(input int k, input string tag);
        check({tag, "_mem_ready"}, 32'(mem_ready_v[k]), 32'd0);
        check({tag, "_rdata"}, rdata_v[k], 32'd0);
        check({tag, "_status"}, status_v[k], 32'd0);
        check({tag, "_status_valid"}, 32'(status_valid_v[k]), 32'd0);
        check({tag, "_addr_err"}, 32'(addr_err_v[k]), 32'd0);
    endtask

    task automatic pulse_reset(input int k);
        @(negedge clk);
        reset_n_v[k] = 1'b0;
        @(negedge clk);
        reset_n_v[k] = 1'b1;
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        logic [7:0] s;
        s = {1'b0, v[7:1]};
        if (v[0]) s = s ^ 8'b1011_1000;
        return s;
    endfunction

    vec_t vecs [16];
    int   lat_o;
    int   r1;

    initial begin
        // Rows run on the WAIT_CYCLES=2 instance; expected flags are checked after each commit.
        vecs[0]  = '{30'd5,    32'hDEADBEEF, 1'b0, 4'hF,    32'h0,        32'h0,    1'b0, 1'b0};
        vecs[1]  = '{30'd5,    32'h0,        1'b1, 4'h0,    32'hDEADBEEF, 32'h0,    1'b0, 1'b0};
        vecs[2]  = '{30'd7,    32'hAABBCCDD, 1'b0, 4'hF,    32'h0,        32'h0,    1'b0, 1'b0};
        vecs[3]  = '{30'd7,    32'h11223344, 1'b0, 4'b0101, 32'h0,        32'h0,    1'b0, 1'b0};
        vecs[4]  = '{30'd7,    32'h0,        1'b1, 4'h0,    32'hAA22CC44, 32'h0,    1'b0, 1'b0};
        vecs[5]  = '{30'd8,    32'hCAFEF00D, 1'b0, 4'hF,    32'h0,        32'h0,    1'b0, 1'b0};
        vecs[6]  = '{30'd8,    32'h12345678, 1'b1, 4'b1000, 32'h0,        32'h0,    1'b0, 1'b0};
        vecs[7]  = '{30'd8,    32'h0,        1'b1, 4'h0,    32'h12FEF00D, 32'h0,    1'b0, 1'b0};
        vecs[8]  = '{30'd2047, 32'h7FF07FF0, 1'b0, 4'hF,    32'h0,        32'h0,    1'b0, 1'b0};
        vecs[9]  = '{30'd2047, 32'h0,        1'b1, 4'h0,    32'h7FF07FF0, 32'h0,    1'b0, 1'b0};
        vecs[10] = '{SA,       32'h00000055, 1'b0, 4'hF,    32'h0,        32'h55,   1'b1, 1'b0};
        vecs[11] = '{SA,       32'h0,        1'b1, 4'h0,    32'h00000055, 32'h55,   1'b1, 1'b0};
        vecs[12] = '{SA,       32'h0000AA00, 1'b0, 4'b0010, 32'h0,        32'hAA55, 1'b1, 1'b0};
        vecs[13] = '{30'd2048, 32'h0,        1'b1, 4'h0,    32'h0,        32'hAA55, 1'b1, 1'b1};
        vecs[14] = '{30'd2055, 32'hFFFFFFFF, 1'b0, 4'hF,    32'h0,        32'hAA55, 1'b1, 1'b1};
        vecs[15] = '{30'd7,    32'h0,        1'b1, 4'h0,    32'hAA22CC44, 32'hAA55, 1'b1, 1'b1};

        for (int k = 0; k < NI; k++) begin
            reset_n_v[k] = 1'b0;
            addr_v[k]    = 30'd0;
            wdata_v[k]   = 32'd0;
            re_v[k]      = 1'b0;
            we_v[k]      = 4'd0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) check_reset_vals(k, $sformatf("reset%0d", k));
        for (int k = 0; k < NI; k++) reset_n_v[k] = 1'b1;

        // Table-driven pass (WAIT_CYCLES=2 -> latency 3)
        for (int i = 0; i < 16; i++) begin
            do_txn(0, $sformatf("row%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].re, vecs[i].we,
                   (vecs[i].we == 4'h0), vecs[i].exp_rdata, 3, lat_o);
            @(negedge clk);
            check($sformatf("row%0d_status", i), status_v[0], vecs[i].exp_status);
            check($sformatf("row%0d_status_valid", i), 32'(status_valid_v[0]), 32'(vecs[i].exp_sv));
            check($sformatf("row%0d_addr_err", i), 32'(addr_err_v[0]), 32'(vecs[i].exp_ae));
        end

        // Zero wait states: back-to-back reads respond two cycles apart
        do_txn(1, "w0_wr0", 30'd0, 32'h01010101, 1'b0, 4'hF, 1'b0, 32'h0, 1, lat_o);
        do_txn(1, "w0_wr1", 30'd1, 32'h02020202, 1'b0, 4'hF, 1'b0, 32'h0, 1, lat_o);
        do_txn(1, "w0_rd0", 30'd0, 32'h0, 1'b1, 4'h0, 1'b1, 32'h01010101, 1, lat_o);
        r1 = last_resp_cyc;
        do_txn(1, "w0_rd1", 30'd1, 32'h0, 1'b1, 4'h0, 1'b1, 32'h02020202, 1, lat_o);
        check("w0_spacing", 32'(last_resp_cyc - r1), 32'd2);

        // Reset during WAIT drops the pending write and clears everything
        do_txn(2, "w3_wr9", 30'd9, 32'h0BADF00D, 1'b0, 4'hF, 1'b0, 32'h0, 4, lat_o);
        do_txn(2, "w3_st", SA, 32'h00000077, 1'b0, 4'hF, 1'b0, 32'h0, 4, lat_o);
        do_txn(2, "w3_oob", 30'd2048, 32'h0, 1'b1, 4'h0, 1'b1, 32'h0, 4, lat_o);
        do_txn(2, "w3_rd9", 30'd9, 32'h0, 1'b1, 4'h0, 1'b1, 32'h0BADF00D, 4, lat_o);
        @(negedge clk);
        check("w3_pre_status", status_v[2], 32'h77);
        check("w3_pre_addr_err", 32'(addr_err_v[2]), 32'd1);
        @(negedge clk);
        addr_v[2] = 30'd9; wdata_v[2] = 32'hFFFFFFFF; we_v[2] = 4'hF;
        repeat (2) @(negedge clk);
        check("w3_wait_low", 32'(mem_ready_v[2]), 32'd0);
        reset_n_v[2] = 1'b0;
        addr_v[2] = 30'd0; wdata_v[2] = 32'd0; we_v[2] = 4'd0;
        #1;
        check_reset_vals(2, "w3_midreset");
        @(negedge clk);
        reset_n_v[2] = 1'b1;
        r1 = 0;
        repeat (8) begin
            @(negedge clk);
            if (mem_ready_v[2] !== 1'b0) r1++;
        end
        check("w3_no_ready", 32'(r1), 32'd0);
        do_txn(2, "w3_rd9_after", 30'd9, 32'h0, 1'b1, 4'h0, 1'b1, 32'h0BADF00D, 4, lat_o);

`ifdef MEM_RAND_WAIT_EN
        begin
            logic [7:0] lf;
            int run1 [16];
            int changes;
            pulse_reset(3);
            lf = 8'hA5;
            for (int i = 0; i < 16; i++) begin
                do_txn(3, $sformatf("rnd1_%0d", i), 30'd0, 32'h0, 1'b1, 4'h0, 1'b0, 32'h0,
                       (int'(lf[3:0]) % 8) + 1, run1[i]);
                lf = lfsr_step(lf);
                check($sformatf("rnd1_%0d_range", i), 32'(run1[i] >= 1 && run1[i] <= 8), 32'd1);
            end
            changes = 0;
            for (int i = 1; i < 16; i++) if (run1[i] != run1[i-1]) changes++;
            check("rnd_varies", 32'(changes > 0), 32'd1);
            pulse_reset(3);
            lf = 8'hA5;
            for (int i = 0; i < 16; i++) begin
                do_txn(3, $sformatf("rnd2_%0d", i), 30'd0, 32'h0, 1'b1, 4'h0, 1'b0, 32'h0,
                       (int'(lf[3:0]) % 8) + 1, lat_o);
                lf = lfsr_step(lf);
                check($sformatf("rnd2_%0d_repeat", i), 32'(lat_o), 32'(run1[i]));
            end
        end
`else
        for (int i = 0; i < 3; i++) begin
            do_txn(3, $sformatf("w7_%0d", i), 30'd0, 32'h0, 1'b1, 4'h0, 1'b0, 32'h0, 8, lat_o);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
